// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants: symbolic op codes, primary opcodes and R-type funct codes.
// Used by both the instruction encoder and the control decoder.
package instr_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_J    = 4'd10
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Codes above OP_J (11..15) have no encoding.
  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= 4'(OP_J);
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry synchronous FIFO with a registered head output that holds its last
// value when the FIFO drains (zero after reset).
module instr_fifo2 #(
  parameter int W     = 40,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [W-1:0] head_q;
  logic [W-1:0] head_d;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'(DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = head_q;

  // Next head: the other slot after a pop from two, the incoming word when it
  // lands in an otherwise empty (or just-drained) FIFO, else unchanged.
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (count == 2'd2)
        head_d = mem[~rd_ptr];
      else if (do_push)
        head_d = din;
    end else if (empty && do_push) begin
      head_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      head_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Assembles 32-bit MIPS instruction words from symbolic requests and queues them
// with sequential instruction-memory word addresses.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic [7:0]        drop_count
);

  localparam int W = 32 + ADDR_W;

  function automatic logic [31:0] encode(
    input logic [3:0]  f_op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [15:0] f_imm,
    input logic [25:0] f_target
  );
    logic [31:0] w;
    w = '0;
    case (op_e'(f_op))
      OP_ADD:  w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_ADD};
      OP_SUB:  w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_SUB};
      OP_AND:  w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_AND};
      OP_OR:   w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_OR};
      OP_SLT:  w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'd0, FN_SLT};
      OP_ADDI: w = {OPC_ADDI, f_rs, f_rt, f_imm};
      OP_LW:   w = {OPC_LW, f_rs, f_rt, f_imm};
      OP_SW:   w = {OPC_SW, f_rs, f_rt, f_imm};
      OP_BEQ:  w = {OPC_BEQ, f_rs, f_rt, f_imm};
      OP_BNE:  w = {OPC_BNE, f_rs, f_rt, f_imm};
      OP_J:    w = {OPC_J, f_target};
      default: w = '0;
    endcase
    return w;
  endfunction

  logic              full;
  logic              empty;
  logic              accept;
  logic              legal;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0]      fifo_din;
  logic [W-1:0]      fifo_dout;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign legal     = op_is_legal(op);
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;
  assign fifo_din  = {encode(op, rs, rt, rd, imm, target), wr_addr};
  assign out_instr = fifo_dout[W-1:ADDR_W];
  assign out_addr  = fifo_dout[ADDR_W-1:0];

  instr_fifo2 #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // Illegal requests complete the handshake but take neither a slot nor an address.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr     <= '0;
      err_illegal <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      if (push)
        wr_addr <= wr_addr + 1'b1;
      if (accept && !legal) begin
        err_illegal <= 1'b1;
        if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default 8-bit address instance plus a
// 2-bit address instance for wrap checks; both share the same stimulus.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [4:0]  rs = 5'd0;
  logic [4:0]  rt = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic [15:0] imm = 16'd0;
  logic [25:0] target = 26'd0;
  logic        out_ready = 1'b0;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        err_illegal;
  logic [7:0]  drop_count;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic        err_illegal2;
  logic [7:0]  drop_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_illegal(err_illegal), .drop_count(drop_count)
  );

  instr_encoder #(.ADDR_W(2), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .err_illegal(err_illegal2), .drop_count(drop_count2)
  );

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
    in_valid = 1'b1;
    op = o; rs = s; rt = t; rd = d; imm = i; target = tg;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    checks++; if (out_addr !== 8'h0) begin errors++; $display("FAIL reset_out_addr got %h want 0", out_addr); end
    checks++; if (err_illegal !== 1'b0 || drop_count !== 8'd0) begin errors++;
      $display("FAIL reset_err got err=%0b drop=%0d want 0/0", err_illegal, drop_count); end
  endtask

  task automatic test_add();
    do_reset();
    out_ready = 1'b1;
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h3FFFFFF);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", out_valid); end
    checks++; if (out_instr !== 32'h00221820) begin errors++; $display("FAIL add_instr got %h want 00221820", out_instr); end
    checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL add_addr got %0d want 0", out_addr); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_one_cycle got %0b want 0", out_valid); end
    checks++; if (out_instr !== 32'h00221820) begin errors++; $display("FAIL add_hold_empty got %h want 00221820", out_instr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    drive(4'd6, 5'd0, 5'd8, 5'd0, 16'h0004, 26'd0);
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_one got %0b want 1", in_ready); end
    drive(4'd7, 5'd0, 5'd8, 5'd0, 16'h0008, 26'd0);
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %0b want 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'h8C080004 || out_addr !== 8'd0) begin errors++;
        $display("FAIL b2b_stall%0d got v=%0b %h@%0d want 1 8c080004@0", k, out_valid, out_instr, out_addr); end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hAC080008 || out_addr !== 8'd1) begin errors++;
      $display("FAIL b2b_second got v=%0b %h@%0d want 1 ac080008@1", out_valid, out_instr, out_addr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got %0b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0b want 0", out_valid); end
  endtask

  task automatic test_branch_jump();
    do_reset();
    out_ready = 1'b1;
    drive(4'd8, 5'd1, 5'd2, 5'd7, 16'hFFFF, 26'd0);
    step();
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h1022FFFF) begin errors++;
      $display("FAIL beq got v=%0b %h want 1 1022ffff", out_valid, out_instr); end
    drive(4'd10, 5'd3, 5'd4, 5'd5, 16'hAAAA, 26'h0000010);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h08000010 || out_addr !== 8'd1) begin errors++;
      $display("FAIL j got v=%0b %h@%0d want 1 08000010@1", out_valid, out_instr, out_addr); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    drive(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'd1);
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL illegal_nopush got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
    checks++; if (err_illegal !== 1'b1 || drop_count !== 8'd1) begin errors++;
      $display("FAIL illegal_flag got err=%0b drop=%0d want 1/1", err_illegal, drop_count); end
    drive(4'd5, 5'd0, 5'd5, 5'd9, 16'h0007, 26'd0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h20050007 || out_addr !== 8'd0) begin errors++;
      $display("FAIL addi got v=%0b %h@%0d want 1 20050007@0", out_valid, out_instr, out_addr); end
    drive(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0);
    repeat (300) step();
    in_valid = 1'b0;
    checks++; if (drop_count !== 8'd255 || err_illegal !== 1'b1) begin errors++;
      $display("FAIL drop_saturate got drop=%0d err=%0b want 255/1", drop_count, err_illegal); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_output got %0b want 0", out_valid); end
  endtask

  task automatic test_addr_wrap();
    logic [1:0] exp_a;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
      step();
      exp_a = 2'(i % 4);
      checks++; if (out_valid2 !== 1'b1 || out_addr2 !== exp_a) begin errors++;
        $display("FAIL wrap%0d got v=%0b addr=%0d want 1 addr=%0d", i, out_valid2, out_addr2, exp_a); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    drive(4'd12, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    step();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    step();
    drive(4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %0b want 0", in_ready); end
    reset = 1'b1;
    drive(4'd2, 5'd7, 5'd7, 5'd7, 16'd0, 26'd0);
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_illegal !== 1'b0 || drop_count !== 8'd0) begin errors++;
      $display("FAIL mid_reset got v=%0b rdy=%0b err=%0b drop=%0d want 0/1/0/0", out_valid, in_ready, err_illegal, drop_count); end
    checks++; if (out_instr !== 32'h0 || out_addr !== 8'd0) begin errors++;
      $display("FAIL mid_reset_out got %h@%0d want 0@0", out_instr, out_addr); end
    out_ready = 1'b1;
    drive(4'd4, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0022182A || out_addr !== 8'd0) begin errors++;
      $display("FAIL mid_after got v=%0b %h@%0d want 1 0022182a@0", out_valid, out_instr, out_addr); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_branch_jump();
    test_illegal();
    test_addr_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
